// File: rtl/mem2io_mmio_pkg.sv
// Shared types and helpers for the mem2io_mmio CPU-to-memory/IO bridge.
package mem2io_pkg;

  typedef enum logic [1:0] {IDLE, IO, MEM, DONE} state_t;

  localparam int IO_SW_OFS  = 0;
  localparam int IO_OUT_OFS = 1;

  // Byte-lane merge: lanes with be set take new_v, others keep old_v.
  function automatic logic [15:0] be_merge(input logic [15:0] old_v,
                                           input logic [15:0] new_v,
                                           input logic [1:0]  be);
    logic [15:0] r;
    r[7:0]  = be[0] ? new_v[7:0]  : old_v[7:0];
    r[15:8] = be[1] ? new_v[15:8] : old_v[15:8];
    return r;
  endfunction

endpackage

// File: rtl/mem2io_mmio_if.sv
// CPU-side bus of the mem2io_mmio bridge.
// Handshake: the CPU raises Req with Wr/Be/A/Data_CPU_In; the bridge samples them
// only when idle and answers with a one-cycle Ack; read data is valid with Ack and held.
interface mem2io_mmio_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();
  logic              Req;
  logic              Wr;
  logic [1:0]        Be;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data_CPU_In;
  logic [DATA_W-1:0] Data_CPU_Out;
  logic              Ack;

  modport master (output Req, Wr, Be, A, Data_CPU_In, input Data_CPU_Out, Ack);
  modport slave  (input Req, Wr, Be, A, Data_CPU_In, output Data_CPU_Out, Ack);
endinterface

// File: rtl/mem2io_mmio_outreg.sv
// One byte-writable board output register with synchronous reset.
module mem2io_outreg
  import mem2io_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= '0;
    end else if (we) begin
      q <= be_merge(q, d, be);
    end
  end

endmodule

// File: rtl/mem2io_mmio.sv
// CPU-to-SRAM/IO bridge: top-of-address IO window plus wait-stated SRAM sequencer.
// Define MEM2IO_READBACK_EN to let reads of output registers return their contents.
module mem2io_mmio
  import mem2io_pkg::*;
#(
  parameter int          ADDR_W   = 20,
  parameter int          DATA_W   = 16,
  parameter int          NUM_OUT  = 2,
  parameter logic [15:0] IO_BASE  = 16'hFFF0,
  parameter int          MEM_WAIT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  mem2io_mmio_if.slave              cpu,
  output logic [ADDR_W-1:0]         Mem_A,
  output logic                      Mem_CE_N,
  output logic                      Mem_OE_N,
  output logic                      Mem_WE_N,
  output logic                      Mem_UB_N,
  output logic                      Mem_LB_N,
  output logic [DATA_W-1:0]         Data_Mem_Out,
  input  logic [DATA_W-1:0]         Data_Mem_In,
  input  logic [DATA_W-1:0]         Switches,
  output logic [NUM_OUT*DATA_W-1:0] Io_Out,
  output state_t                    Dbg_State
);

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              lat_en, ack;
  logic [ADDR_W-1:0] a_q;
  logic              wr_q;
  logic [1:0]        be_q;
  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] io_rd;
  logic              io_hit;
  logic [3:0]        ofs_in, ofs_q;

  assign io_hit = (cpu.A[15:4] == IO_BASE[15:4]);
  assign ofs_in = cpu.A[3:0];
  assign ofs_q  = a_q[3:0];

  // IO read data is captured on the accepting edge so it is stable alongside Ack.
  always_comb begin
    io_rd = '0;
    if (ofs_in == 4'(IO_SW_OFS)) io_rd = Switches;
`ifdef MEM2IO_READBACK_EN
    for (int k = 0; k < NUM_OUT; k++) begin
      if (ofs_in == 4'(k + IO_OUT_OFS)) io_rd = Io_Out[k*DATA_W +: DATA_W];
    end
`endif
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    lat_en   = 1'b0;
    ack      = 1'b0;
    Mem_CE_N = 1'b1;
    Mem_OE_N = 1'b1;
    Mem_WE_N = 1'b1;
    Mem_UB_N = 1'b1;
    Mem_LB_N = 1'b1;
    case (state)
      IDLE: begin
        if (cpu.Req) begin
          lat_en  = 1'b1;
          state_d = io_hit ? IO : MEM;
          cnt_d   = 4'(MEM_WAIT);
        end
      end
      IO: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      MEM: begin
        Mem_CE_N = 1'b0;
        Mem_UB_N = ~be_q[1];
        Mem_LB_N = ~be_q[0];
        Mem_OE_N = wr_q;
        Mem_WE_N = ~wr_q;
        if (cnt == 4'd0) state_d = DONE;
        else             cnt_d   = cnt - 4'd1;
      end
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      d_q     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (lat_en) begin
        a_q  <= cpu.A;
        wr_q <= cpu.Wr;
        be_q <= cpu.Be;
        d_q  <= cpu.Data_CPU_In;
        if (io_hit && !cpu.Wr) rdata_q <= io_rd;
      end
      if (state == MEM && cnt == 4'd0 && !wr_q) rdata_q <= Data_Mem_In;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic we_k;
    assign we_k = (state == IO) && wr_q && (ofs_q == 4'(k + IO_OUT_OFS));
    mem2io_outreg #(.DATA_W(DATA_W)) u_reg (
      .Clk  (Clk),
      .Reset(Reset),
      .we   (we_k),
      .be   (be_q),
      .d    (d_q),
      .q    (Io_Out[k*DATA_W +: DATA_W])
    );
  end

  assign cpu.Ack          = ack;
  assign cpu.Data_CPU_Out = rdata_q;
  assign Mem_A            = a_q;
  assign Data_Mem_Out     = d_q;
  assign Dbg_State        = state;

endmodule

// File: tb/tb_mem2io_mmio.sv
// Self-checking bench for mem2io_mmio: transaction-level model plus directed literal checks.
module tb_mem2io_mmio;
  import mem2io_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int NO = 2;
  localparam int MW = 2;
`ifdef MEM2IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [AW-1:0]    Mem_A;
  logic             Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_UB_N, Mem_LB_N;
  logic [DW-1:0]    Data_Mem_Out, Data_Mem_In, Switches;
  logic [NO*DW-1:0] Io_Out;
  state_t           Dbg_State;

  mem2io_mmio_if #(.ADDR_W(AW), .DATA_W(DW)) cpu ();

  mem2io_mmio #(.ADDR_W(AW), .DATA_W(DW), .NUM_OUT(NO), .IO_BASE(16'hFFF0), .MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .cpu(cpu),
    .Mem_A(Mem_A), .Mem_CE_N(Mem_CE_N), .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N),
    .Mem_UB_N(Mem_UB_N), .Mem_LB_N(Mem_LB_N), .Data_Mem_Out(Data_Mem_Out),
    .Data_Mem_In(Data_Mem_In), .Switches(Switches), .Io_Out(Io_Out), .Dbg_State(Dbg_State)
  );

  always #5 Clk = ~Clk;

  int vec = 0;
  int mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: each accepted request is a record with its ack cycle.
  int            cyc = 0;
  bit            m_ready = 1'b0;
  bit            m_busy, m_mem, m_wr;
  logic [AW-1:0] m_a;
  logic [1:0]    m_be;
  logic [DW-1:0] m_d, m_rdata;
  logic [DW-1:0] m_regs [NO];
  int            m_c0, m_ack_cyc;
  bit            e_ack, e_act;

  initial begin
    forever begin
      @(posedge Clk);
      if (Reset) begin
        m_busy  = 1'b0;
        m_rdata = '0;
        for (int k = 0; k < NO; k++) m_regs[k] = '0;
      end else if (!m_busy) begin
        if (cpu.Req) begin
          int off;
          m_c0   = cyc;
          m_a    = cpu.A;
          m_wr   = cpu.Wr;
          m_be   = cpu.Be;
          m_d    = cpu.Data_CPU_In;
          m_mem  = (cpu.A[15:4] != 12'hFFF);
          m_busy = 1'b1;
          m_ack_cyc = m_mem ? cyc + MW + 2 : cyc + 1;
          off = int'(cpu.A[3:0]);
          if (!m_mem && !m_wr) begin
            if (off == 0) m_rdata = Switches;
            else if (off >= 1 && off <= NO) m_rdata = RB ? m_regs[off-1] : '0;
            else m_rdata = '0;
          end
        end
      end else begin
        if (m_mem && !m_wr && cyc == m_ack_cyc - 1) m_rdata = Data_Mem_In;
        if (cyc == m_ack_cyc) begin
          int off;
          m_busy = 1'b0;
          off = int'(m_a[3:0]);
          if (!m_mem && m_wr && off >= 1 && off <= NO) begin
            if (m_be[0]) m_regs[off-1][7:0]  = m_d[7:0];
            if (m_be[1]) m_regs[off-1][15:8] = m_d[15:8];
          end
        end
      end
      cyc++;
      e_ack   = m_busy && (cyc == m_ack_cyc);
      e_act   = m_busy && m_mem && (cyc >= m_c0 + 1) && (cyc <= m_c0 + MW + 1);
      m_ready = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (m_ready) begin
        logic [NO*DW-1:0] e_io;
        for (int k = 0; k < NO; k++) e_io[k*DW +: DW] = m_regs[k];
        check("ack", cpu.Ack, e_ack);
        check("ce_n", Mem_CE_N, !e_act);
        check("oe_n", Mem_OE_N, !(e_act && !m_wr));
        check("we_n", Mem_WE_N, !(e_act && m_wr));
        check("ub_n", Mem_UB_N, !(e_act && m_be[1]));
        check("lb_n", Mem_LB_N, !(e_act && m_be[0]));
        check("oe_we_excl", Mem_OE_N | Mem_WE_N, 1'b1);
        check("cpu_rdata", cpu.Data_CPU_Out, m_rdata);
        check("io_out", Io_Out, e_io);
        if (e_act) check("mem_a", Mem_A, m_a);
        if (e_act && m_wr) check("mem_wdata", Data_Mem_Out, m_d);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where the next Req may start.
  task automatic access(input logic [AW-1:0] a, input bit wr, input logic [1:0] be,
                        input logic [DW-1:0] d, input bit noise,
                        output int lat, output int oe_cnt, output int we_cnt,
                        output int ub_cnt, output int lb_cnt);
    bit got;
    cpu.Req = 1'b1; cpu.A = a; cpu.Wr = wr; cpu.Be = be; cpu.Data_CPU_In = d;
    lat = 0; oe_cnt = 0; we_cnt = 0; ub_cnt = 0; lb_cnt = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      lat++;
      if (!Mem_OE_N) oe_cnt++;
      if (!Mem_WE_N) we_cnt++;
      if (!Mem_UB_N) ub_cnt++;
      if (!Mem_LB_N) lb_cnt++;
      if (cpu.Ack) begin
        got = 1'b1;
        break;
      end
      if (noise) begin
        cpu.Req = 1'($urandom_range(0, 1));
        cpu.A = AW'($urandom); cpu.Wr = 1'($urandom); cpu.Be = 2'($urandom);
        cpu.Data_CPU_In = DW'($urandom); Data_Mem_In = DW'($urandom);
      end else begin
        cpu.Req = 1'b0;
      end
    end
    cpu.Req = 1'b0;
    if (!got) check("ack_timeout", 1'b0, 1'b1);
    @(negedge Clk);
  endtask

  initial begin
    int lat, oe, we, ub, lb;
    bit seen;
    cpu.Req = 1'b0; cpu.Wr = 1'b0; cpu.Be = '0; cpu.A = '0; cpu.Data_CPU_In = '0;
    Data_Mem_In = '0; Switches = '0;
    repeat (3) @(negedge Clk);
    check("rst_io_out", Io_Out, '0);
    check("rst_ack", cpu.Ack, 1'b0);
    check("rst_strobes", {Mem_CE_N, Mem_OE_N, Mem_WE_N, Mem_UB_N, Mem_LB_N}, 5'b11111);
    check("rst_mem_a", Mem_A, '0);
    check("rst_mem_wdata", Data_Mem_Out, '0);
    check("rst_cpu_rdata", cpu.Data_CPU_Out, '0);
    check("rst_state", Dbg_State, IDLE);
    Reset = 1'b0;
    @(negedge Clk);

    access(20'h0FFF1, 1'b1, 2'b11, 16'hBEEF, 1'b0, lat, oe, we, ub, lb);
    check("io_wr_lat", lat, 1);
    access(20'h0FFF1, 1'b1, 2'b10, 16'h12AB, 1'b0, lat, oe, we, ub, lb);
    check("io_wr2_lat", lat, 1);
    check("io_merge", Io_Out[15:0], 16'h12EF);

    Switches = 16'hA5A5;
    access(20'h0FFF0, 1'b0, 2'b11, 16'h0000, 1'b0, lat, oe, we, ub, lb);
    check("sw_rd_lat", lat, 1);
    check("sw_rd_data", cpu.Data_CPU_Out, 16'hA5A5);
    access(20'h0FFF0, 1'b1, 2'b11, 16'h1234, 1'b0, lat, oe, we, ub, lb);
    check("sw_wr_ignored", Io_Out, 32'h0000_12EF);
    check("wr_keeps_rdata", cpu.Data_CPU_Out, 16'hA5A5);

    Data_Mem_In = 16'h5555;
    access(20'h00123, 1'b0, 2'b11, 16'h0000, 1'b0, lat, oe, we, ub, lb);
    check("mem_rd_lat", lat, 4);
    check("mem_rd_oe_cycles", oe, 3);
    check("mem_rd_data", cpu.Data_CPU_Out, 16'h5555);

    access(20'h04567, 1'b1, 2'b01, 16'hC3C3, 1'b0, lat, oe, we, ub, lb);
    check("mem_wr_we_cycles", we, MW + 1);
    check("mem_wr_lb_cycles", lb, MW + 1);
    check("mem_wr_ub_cycles", ub, 0);
    // Issued in the cycle right after the previous Ack.
    access(20'h0FFF2, 1'b1, 2'b11, 16'h0F0F, 1'b0, lat, oe, we, ub, lb);
    check("b2b_lat", lat, 1);
    access(20'h0FFF2, 1'b0, 2'b11, 16'h0000, 1'b0, lat, oe, we, ub, lb);
    check("readback_reg1", cpu.Data_CPU_Out, RB ? 16'h0F0F : 16'h0000);
    access(20'h0FFFE, 1'b0, 2'b11, 16'h0000, 1'b0, lat, oe, we, ub, lb);
    check("unmapped_rd", cpu.Data_CPU_Out, 16'h0000);

    access(20'h0FFF1, 1'b1, 2'b00, 16'hFFFF, 1'b0, lat, oe, we, ub, lb);
    check("be00_io_lat", lat, 1);
    check("be00_io_noop", Io_Out, 32'h0F0F_12EF);
    access(20'h00777, 1'b1, 2'b00, 16'hFFFF, 1'b0, lat, oe, we, ub, lb);
    check("be00_mem_lat", lat, MW + 2);
    check("be00_mem_bytes", ub + lb, 0);

    // Reset in the middle of an SRAM read.
    cpu.Req = 1'b1; cpu.A = 20'h00200; cpu.Wr = 1'b0; cpu.Be = 2'b11;
    @(negedge Clk);
    cpu.Req = 1'b0;
    check("mid_rst_ce_active", Mem_CE_N, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid_rst_ce_n", Mem_CE_N, 1'b1);
    check("mid_rst_oe_n", Mem_OE_N, 1'b1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      if (cpu.Ack) seen = 1'b1;
    end
    check("mid_rst_no_ack", seen, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1) a[15:4] = 12'hFFF;
      else if (a[15:4] == 12'hFFF) a[15:4] = 12'h000;
      Switches = DW'($urandom);
      access(a, 1'($urandom), 2'($urandom), DW'($urandom), 1'b1, lat, oe, we, ub, lb);
    end

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
